uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//   UART receiver, 8N1-style async serial: start bit, DATA_BITS data bits LSB first, one stop bit.
//   Sits beside the baud generator and consumes its oversample tick (OVERSAMPLE ticks per bit).
//   Synchronises the rx line, validates the start bit at mid-bit and samples each bit at its centre.
//   Presents received words on a valid/ready port with framing-error and overrun flags.
//
// PARAMETERS
//   DATA_BITS   8    data bits per frame (5..9)
//   OVERSAMPLE  16   sample_tick pulses per bit period; even, >= 4
//
// PORTS
//   clk          in   1          system clock, all logic on posedge
//   rst          in   1          asynchronous, active-high reset
//   rx           in   1          serial line, idle high; asynchronous to clk
//   sample_tick  in   1          1-clk pulse, OVERSAMPLE x baud rate
//   rx_data      out  DATA_BITS  last received word; held until overwritten
//   rx_valid     out  1          rx_data holds an unconsumed word
//   rx_ready     in   1          consumer accepts; handshake = rx_valid & rx_ready
//   frame_err    out  1          1-clk pulse: stop bit sampled low
//   overrun      out  1          sticky: unconsumed word overwritten
//
// BEHAVIOUR
//   Reset (async assert): state=IDLE, counters 0, sync flops=1, rx_data=0, rx_valid=0,
//     frame_err=0, overrun=0. Reset mid-frame aborts the frame; no partial word output.
//   Input: rx through 2-flop synchroniser (reset to 1); FSM uses synchronised rx only.
//   tick_cnt (log2 OVERSAMPLE bits) and bit_cnt advance only on sample_tick cycles.
//   FSM:
//     IDLE : on tick with rx==0 -> START, tick_cnt=0.
//     START: on tick, tick_cnt++; at tick_cnt==OVERSAMPLE/2-1 (mid start bit):
//            rx==0 -> DATA, tick_cnt=0, bit_cnt=0; rx==1 -> IDLE (glitch rejected).
//     DATA : on tick, tick_cnt++; at tick_cnt==OVERSAMPLE-1: shift rx into shreg MSB
//            (shift right, LSB first), tick_cnt=0, bit_cnt++; after bit DATA_BITS-1 -> STOP.
//     STOP : at tick_cnt==OVERSAMPLE-1 (mid stop bit) -> IDLE, and:
//            rx==1: rx_data<=shreg, rx_valid<=1 (next clk edge);
//            rx==0: frame_err=1 for exactly one clk; rx_data/rx_valid unchanged.
//   Returning to IDLE at mid-stop lets a back-to-back start bit be detected.
//   Handshake: rx_valid & rx_ready clears rx_valid next edge.
//   Word completes while rx_valid=1 and no handshake that cycle: rx_data overwritten,
//     rx_valid stays 1, overrun<=1.
//   Word completes in same cycle as handshake: rx_valid stays 1 with new data, no overrun.
//   overrun clears on the next handshake; set has priority over clear (cannot coincide).
//   Latency: rx_valid rises 1 clk after the sample_tick cycle that samples stop-bit centre.
//   sample_tick in the same cycle as reset deassertion is ignored.
//
// TESTING (DATA_BITS=8, OVERSAMPLE=16, sample_tick every 54 clk)
//   1. Frame 0xA5, good stop, rx_ready=1 -> rx_data=0xA5, rx_valid high 1 clk, frame_err=0.
//   2. rx low 4 ticks then high, idle 2 bit times -> stays IDLE, rx_valid=0, frame_err=0.
//   3. Frame 0x3C, stop bit driven 0 -> frame_err 1-clk pulse, rx_valid=0, rx_data unchanged.
//   4. rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x22, rx_valid=1, overrun=1;
//      then rx_ready=1 -> rx_valid=0, overrun=0 next clk.
//   5. rst pulse after 3 data bits of 0x77 -> all outputs 0 immediately;
//      then frame 0x5A -> rx_data=0x5A, overrun=0, frame_err=0.
//   6. Back-to-back 0x00 and 0xFF, no idle gap, rx_ready=1 -> two valid words, 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit, sampled
// at bit centres using an OVERSAMPLE-rate tick; output on a valid/ready port.
`timescale 1ns/1ps

module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 sample_tick,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS) + 1;

   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state, state_d;
   logic [TW-1:0]        tick_cnt, tick_d;
   logic [BW-1:0]        bit_cnt, bit_d;
   logic [DATA_BITS-1:0] shreg, shreg_d;
   logic                 rx_meta, rx_sync;
   logic                 word_done, stop_bad;
   logic                 handshake;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         // NOTE: non-blocking so rx_sync takes the previous rx_meta, forming two real stages.
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path through the case leaves a latch.
      state_d   = state;
      tick_d    = tick_cnt;
      bit_d     = bit_cnt;
      shreg_d   = shreg;
      word_done = 1'b0;
      stop_bad  = 1'b0;
      if (sample_tick) begin
         unique case (state)
            IDLE: begin
               if (!rx_sync) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               if (tick_cnt == TICK_MID) begin
                  tick_d = '0;
                  if (!rx_sync) begin
                     state_d = DATA;
                     bit_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_cnt + TW'(1);
               end
            end
            DATA: begin
               if (tick_cnt == TICK_END) begin
                  shreg_d = {rx_sync, shreg[DATA_BITS-1:1]};
                  tick_d  = '0;
                  bit_d   = bit_cnt + BW'(1);
                  if (bit_cnt == LAST_BIT) state_d = STOP;
               end else begin
                  tick_d = tick_cnt + TW'(1);
               end
            end
            STOP: begin
               // Leaving at mid-stop lets a back-to-back start edge be caught.
               if (tick_cnt == TICK_END) begin
                  state_d   = IDLE;
                  tick_d    = '0;
                  word_done = rx_sync;
                  stop_bad  = !rx_sync;
               end else begin
                  tick_d = tick_cnt + TW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         state    <= state_d;
         tick_cnt <= tick_d;
         bit_cnt  <= bit_d;
         shreg    <= shreg_d;
      end
   end

   assign handshake = rx_valid & rx_ready;

   // A completing word wins over a handshake in the same cycle: valid stays up with new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         if (word_done) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (handshake) begin
            rx_valid <= 1'b0;
         end
         if (word_done && rx_valid && !rx_ready) begin
            overrun <= 1'b1;
         end else if (handshake) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, with a
// queue scoreboard of expected words and expected framing errors checked by a monitor.
`timescale 1ns/1ps

module tb_uart_rx;
   localparam int DB = 8;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx = 1'b1;
   logic          sample_tick = 1'b0;
   logic          rx_ready = 1'b1;
   logic [DB-1:0] rx_data;
   logic          rx_valid, frame_err, overrun;

   uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .clk(clk), .rst(rst), .rx(rx), .sample_tick(sample_tick),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   int            tick_div = 54;
   logic [DB-1:0] exp_q[$];
   int            fe_pending = 0;
   int            fe_count = 0;
   int            popped = 0;
   int            vlen = 0;
   int            last_vlen = 0;
   logic          fe_prev = 1'b0;
   logic [DB-1:0] exp_word;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Tick source: one-clock pulse every tick_div clocks.
   initial begin
      int c = 0;
      forever begin
         @(posedge clk);
         #1;
         c++;
         if (c >= tick_div) c = 0;
         sample_tick = (c == 0);
      end
   end

   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      clks(OS * tick_div);
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i]);
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || fe_pending != 0) && n < 4 * OS * tick_div) begin
         clks(1);
         n++;
      end
      check("drain_words", exp_q.size(), 0);
      check("drain_frame_err", fe_pending, 0);
   endtask

   // Monitor: sampled on the falling edge, between input changes and active edges.
   always @(negedge clk) begin
      if (rst) begin
         vlen    = 0;
         fe_prev = 1'b0;
      end else begin
         if (rx_valid) vlen++;
         else if (vlen != 0) begin
            last_vlen = vlen;
            vlen      = 0;
         end
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h want none", rx_data);
            end else begin
               exp_word = exp_q.pop_front();
               popped++;
               check("rx_data", rx_data, exp_word);
            end
         end
         if (frame_err) begin
            fe_count++;
            check("frame_err_width", fe_prev, 0);
            if (fe_pending == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame_err: got 1 want 0");
            end else begin
               fe_pending--;
            end
         end
         fe_prev = frame_err;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            fe0;
      int            p0;
      logic [DB-1:0] d;
      logic          stop;
      int            gap;

      // Reset state
      clks(3);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      clks(5);

      // 1: good frame, consumer ready
      fe0 = fe_count;
      last_vlen = 0;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      drain();
      check("t1_rx_data", rx_data, 8'hA5);
      check("t1_valid_len", last_vlen, 1);
      check("t1_frame_err", fe_count - fe0, 0);

      // 2: short low glitch is rejected
      rx = 1'b0;
      clks(4 * tick_div);
      rx = 1'b1;
      clks(2 * OS * tick_div);
      check("t2_rx_valid", rx_valid, 0);
      check("t2_frame_err", fe_count - fe0, 0);

      // 3: stop bit low
      fe_pending++;
      send_frame(8'h3C, 1'b0);
      clks(OS * tick_div);
      drain();
      check("t3_rx_data", rx_data, 8'hA5);
      check("t3_rx_valid", rx_valid, 0);
      check("t3_frame_err", fe_count - fe0, 1);

      // 4: overrun with consumer stalled
      tick_div = 8;
      clks(2 * OS * tick_div);
      rx_ready = 1'b0;
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1);
      check("t4_first_valid", rx_valid, 1);
      check("t4_first_overrun", overrun, 0);
      send_frame(8'h22, 1'b1);
      clks(OS * tick_div / 2);
      check("t4_rx_valid", rx_valid, 1);
      check("t4_rx_data", rx_data, 8'h22);
      check("t4_overrun", overrun, 1);
      rx_ready = 1'b1;
      clks(1);
      check("t4_valid_clr", rx_valid, 0);
      check("t4_overrun_clr", overrun, 0);
      drain();

      // 5: reset mid-frame
      fe0 = fe_count;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      rst = 1'b1;
      #1;
      check("t5_rx_data", rx_data, 0);
      check("t5_rx_valid", rx_valid, 0);
      check("t5_frame_err", frame_err, 0);
      check("t5_overrun", overrun, 0);
      rx = 1'b1;
      clks(3);
      rst = 1'b0;
      clks(2 * OS * tick_div);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      drain();
      check("t5_new_data", rx_data, 8'h5A);
      check("t5_new_overrun", overrun, 0);
      check("t5_new_frame_err", fe_count - fe0, 0);

      // 6: back-to-back frames, no idle gap
      p0 = popped;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      drain();
      check("t6_words", popped - p0, 2);

      // Random frames: stop bit mostly good, idle gaps of 0..2 bit times
      for (int n = 0; n < 20; n++) begin
         d    = DB'($urandom);
         stop = ($urandom_range(0, 6) != 0);
         gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         if (stop) exp_q.push_back(d);
         else fe_pending++;
         send_frame(d, stop);
         clks(gap * OS * tick_div);
      end
      drain();
      check("final_overrun", overrun, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
